// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        SUB_IDLE = 2'd0,
        SUB_BUSY = 2'd1,
        SUB_DONE = 2'd2
    } sub_state_e;

    // Counter must hold 0..width-1 and is never narrower than one bit.
    function automatic int sub_cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two half-subtractor cells; purely
// combinational slice used by the serial datapath.
module full_subtractor (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y,
    input  logic bi
);

    logic d_half;
    logic bo_first;
    logic bo_second;

    // First cell computes x - y, second subtracts the incoming borrow.
    assign d_half    = x ^ y;
    assign bo_first  = ~x & y;
    assign d         = d_half ^ bi;
    assign bo_second = ~d_half & bi;
    assign bo        = bo_first | bo_second;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b, LSB first, registered borrow).
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = sub_cnt_width(WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; the producer holds its payload until then, and the consumer
    // never sees ready depend combinationally on its own valid.
    sub_state_e       state;
    sub_state_e       state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] d_msb;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             borrow_q;
    logic             out_valid_q;
    logic             bit_d;
    logic             bit_bo;
    logic             accept;
    logic             last_bit;
    logic             release_res;

    assign accept      = in_valid && in_ready;
    assign last_bit    = (cnt == CW'(WIDTH - 1));
    assign release_res = out_valid_q && out_ready;

    full_subtractor u_slice (
        .d  (bit_d),
        .bo (bit_bo),
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SUB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SUB_IDLE: if (accept)      state_next = SUB_BUSY;
            SUB_BUSY: if (last_bit)    state_next = SUB_DONE;
            SUB_DONE: if (release_res) state_next = SUB_IDLE;
            default:                   state_next = SUB_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == SUB_IDLE);
    end

    // New result bit enters at the MSB so the LSB-first stream lands in place.
    always_comb begin
        d_msb            = '0;
        d_msb[WIDTH-1]   = bit_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr        <= '0;
            b_sr        <= '0;
            diff_sr     <= '0;
            cnt         <= '0;
            borrow      <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                SUB_IDLE: begin
                    if (accept) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        diff_sr <= '0;
                        cnt     <= '0;
                        borrow  <= 1'b0;
                    end
                end
                SUB_BUSY: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= (diff_sr >> 1) | d_msb;
                    borrow  <= bit_bo;
                    cnt     <= cnt + 1'b1;
                end
                SUB_DONE: begin
                    // Output registers load on the first DONE cycle and clear on release.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        diff_q      <= diff_sr;
                        borrow_q    <= borrow;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        diff_q      <= '0;
                        borrow_q    <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == SUB_DONE && !out_valid_q) begin
                ovf_q <= (a_msb ^ b_msb) & (a_msb ^ diff_sr[WIDTH-1]);
            end else if (release_res) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8, 1 and 32; overflow expectations
// follow SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        bo;
        logic        ov;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;

    logic        ir8, ov8, bo8, of8;
    logic [7:0]  diff8;
    logic        ir1, ov1, bo1, of1;
    logic [0:0]  diff1;
    logic        ir32, ov32, bo32, of32;
    logic [31:0] diff32;

    logic        ir_m, ov_m, bo_m, of_m;
    logic [31:0] diff_m;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel == 8), .in_ready(ir8),
        .a(a_drv[7:0]), .b(b_drv[7:0]),
        .out_valid(ov8), .out_ready(out_ready && sel == 8),
        .diff(diff8), .borrow_out(bo8), .overflow(of8)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel == 1), .in_ready(ir1),
        .a(a_drv[0:0]), .b(b_drv[0:0]),
        .out_valid(ov1), .out_ready(out_ready && sel == 1),
        .diff(diff1), .borrow_out(bo1), .overflow(of1)
    );

    serial_subtractor #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel == 32), .in_ready(ir32),
        .a(a_drv), .b(b_drv),
        .out_valid(ov32), .out_ready(out_ready && sel == 32),
        .diff(diff32), .borrow_out(bo32), .overflow(of32)
    );

    always_comb begin
        ir_m = ir8; ov_m = ov8; bo_m = bo8; of_m = of8; diff_m = {24'd0, diff8};
        case (sel)
            1:  begin ir_m = ir1;  ov_m = ov1;  bo_m = bo1;  of_m = of1;  diff_m = {31'd0, diff1}; end
            32: begin ir_m = ir32; ov_m = ov32; bo_m = bo32; of_m = of32; diff_m = diff32; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic bo, output logic ov);
        longint m, ia, ib, sa, sb, sd, half;
        m    = 64'sd1 <<< w;
        half = m / 2;
        ia   = longint'(a) % m;
        ib   = longint'(b) % m;
        d    = 32'((ia - ib + m) % m);
        bo   = (ia < ib);
        sa   = (ia >= half) ? ia - m : ia;
        sb   = (ib >= half) ? ib - m : ib;
        sd   = sa - sb;
        ov   = OVF_EN && ((sd < -half) || (sd > half - 1));
    endtask

    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit poke,
                         output logic [31:0] d, output logic bo, output logic ov, output int lat);
        logic busy_ir, busy_out, moved;
        sel = w; a_drv = a; b_drv = b; out_ready = 1'b0;
        d = '0; bo = 1'b0; ov = 1'b0;
        #1;
        check("in_ready_idle", 32'(ir_m), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a_drv = $urandom; b_drv = $urandom;
        lat = 0; busy_ir = 1'b0; busy_out = 1'b0;
        while (!ov_m && lat < 100) begin
            busy_ir  |= ir_m;
            busy_out |= (diff_m != 0) || bo_m || of_m;
            if (poke && lat == 1) in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat++;
        end
        if (!ov_m) begin
            check("out_valid_timeout", 32'(ov_m), 32'd1);
            return;
        end
        check("in_ready_busy", 32'(busy_ir), 32'd0);
        check("outputs_zero_busy", 32'(busy_out), 32'd0);
        d = diff_m; bo = bo_m; ov = of_m;
        moved = 1'b0;
        repeat (stall) begin
            tick();
            moved |= (diff_m != d) || (bo_m != bo) || (of_m != ov) || !ov_m || ir_m;
        end
        if (stall > 0) check("hold_stable", 32'(moved), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("released_out_valid", 32'(ov_m), 32'd0);
        check("released_diff", diff_m, 32'd0);
        check("released_in_ready", 32'(ir_m), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] d, ed;
        logic        bo, ov, ebo, eov;
        int          lat;
        logic [32:0] exp_word;

        vecs.push_back('{8,  32'h05, 32'h03, 32'h02, 1'b0, 1'b0, 9});
        vecs.push_back('{8,  32'h03, 32'h05, 32'hFE, 1'b1, 1'b0, 9});
        vecs.push_back('{8,  32'h00, 32'h00, 32'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{8,  32'h80, 32'h01, 32'h7F, 1'b0, 1'b1, 9});
        vecs.push_back('{8,  32'h7F, 32'hFF, 32'h80, 1'b1, 1'b1, 9});
        vecs.push_back('{8,  32'hFF, 32'h01, 32'hFE, 1'b0, 1'b0, 9});
        vecs.push_back('{8,  32'h00, 32'hFF, 32'h01, 1'b1, 1'b0, 9});
        vecs.push_back('{1,  32'h0,  32'h1,  32'h1,  1'b1, 1'b1, 2});
        vecs.push_back('{1,  32'h1,  32'h0,  32'h1,  1'b0, 1'b0, 2});
        vecs.push_back('{1,  32'h1,  32'h1,  32'h0,  1'b0, 1'b0, 2});
        vecs.push_back('{32, 32'h0,  32'h1,  32'hFFFF_FFFF, 1'b1, 1'b0, 33});
        vecs.push_back('{32, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 33});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 8;
        a_drv = '0; b_drv = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(ir_m), 32'd1);
        check("reset_out_valid", 32'(ov_m), 32'd0);
        check("reset_diff", diff_m, 32'd0);
        check("reset_borrow", 32'(bo_m), 32'd0);
        check("reset_overflow", 32'(of_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            do_op(vecs[i].w, vecs[i].a, vecs[i].b, 0, 1'b0, d, bo, ov, lat);
            check($sformatf("vec%0d_diff", i), d, vecs[i].d);
            check($sformatf("vec%0d_borrow", i), 32'(bo), 32'(vecs[i].bo));
            check($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].ov && OVF_EN));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure for 5 cycles plus an in_valid pulse while busy.
        do_op(8, 32'h5A, 32'h3C, 5, 1'b1, d, bo, ov, lat);
        check("bp_diff", d, 32'h1E);
        check("bp_borrow", 32'(bo), 32'd0);
        check("bp_latency", 32'(lat), 32'd9);

        // Reset asserted at bit 4 of an operation.
        sel = 8; a_drv = 32'hAA; b_drv = 32'h55;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(ov_m), 32'd0);
        check("midrst_diff", diff_m, 32'd0);
        check("midrst_borrow", 32'(bo_m), 32'd0);
        check("midrst_overflow", 32'(of_m), 32'd0);
        check("midrst_in_ready", 32'(ir_m), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(8, 32'hFF, 32'h01, 0, 1'b0, d, bo, ov, lat);
        check("after_rst_diff", d, 32'hFE);
        check("after_rst_borrow", 32'(bo), 32'd0);
        check("after_rst_latency", 32'(lat), 32'd9);

        // Random sweeps against the arithmetic model.
        foreach (vecs[k]) begin
            if (k == 0) begin
                for (int wi = 0; wi < 2; wi++) begin
                    int w;
                    w = (wi == 0) ? 8 : 32;
                    for (int n = 0; n < 1000; n++) begin
                        logic [31:0] ra, rb;
                        ra = $urandom;
                        rb = (n % 7 == 0) ? ra : $urandom;
                        ref_sub(w, ra, rb, ed, ebo, eov);
                        exp_q.push_back({ebo, ed});
                        do_op(w, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                              d, bo, ov, lat);
                        exp_word = exp_q.pop_front();
                        check($sformatf("rand_w%0d_diff a=%0h b=%0h", w, ra, rb), d, exp_word[31:0]);
                        check($sformatf("rand_w%0d_borrow", w), 32'(bo), 32'(exp_word[32]));
                        check($sformatf("rand_w%0d_overflow", w), 32'(ov), 32'(eov));
                        check($sformatf("rand_w%0d_latency", w), 32'(lat), 32'(w + 1));
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
